priority_interrupt_controller: RTL and testbench
================================================

// Module: priority_interrupt_controller
// PURPOSE
//  Parametrised successor interrupt controller: N sources, per-source level/edge mode, latched edge pending,
//  write-1-to-clear, and a claim/complete handshake with fixed lowest-index-wins priority.
//  Sits on the peripheral bus beside the other memory-mapped devices; drives the CPU external-interrupt line.
// PARAMETERS
//  NUM_SOURCES  32  number of interrupt sources, 1..32; word_t bits >= NUM_SOURCES read 0, writes ignored
// PORTS
//  clk_i          in   1   system clock, the only clock
//  reset_ni       in   1   asynchronous, active-low reset
//  interrupt_i    in   32  raw source requests; bits >= NUM_SOURCES ignored
//  interrupt_o    out  1   high while any source is active
//  chip_select_i  in   1   bus select
//  addr_i         in   4   word index of the register
//  read_enable_i  in   1   read strobe
//  read_data_o    out  32  registered read data
//  write_data_i   in   32  write data
//  write_mask_i   in   4   per-byte write enables
// BEHAVIOUR
//  Reset: sampled/prev/pending/enabled/mode/in_service = 0; read_data_o = 0; interrupt_o = 0.
//  Sampling: sampled_r <= interrupt_i each clock; prev_r <= sampled_r.
//  Level source (mode=0): pending = sampled_r (not latched). Input high before edge k -> pending after k.
//  Edge source (mode=1): pending_r set when sampled_r & ~prev_r. Input rising before edge k -> pending after k+1.
//    Stays set until W1C or claim. Set and clear in the same cycle: set wins.
//  active = pending & enabled & ~in_service; interrupt_o = |active, combinational from registers.
//  Register map (addr_i):
//    0 PENDING   R; W1C on edge-mode bits under write_mask_i; level-mode bits ignore writes
//    1 ENABLED   RW, byte-masked
//    2 ACTIVE    R
//    3 MODE      RW, byte-masked; 1 = edge, 0 = level; changing mode clears that bit's latched pending
//    4 CLAIM     R: id+1 of lowest-index active source, 0 if none. W: complete
//    5 RAW       R: sampled_r (synchronised levels)
//    6..15       read 0, writes ignored
//  Reads: chip_select_i & read_enable_i at edge k -> read_data_o valid after k; otherwise read_data_o holds.
//  Claim: CLAIM read with id != 0 -> in same edge set in_service[id-1], clear edge pending[id-1].
//    Read returning 0 has no side effect. One claim per strobed cycle.
//  Complete: CLAIM write with write_mask_i[0] and write_data_i[7:0] = id+1, 1 <= id+1 <= NUM_SOURCES
//    -> clear in_service[id]. 0, out-of-range, or not-in-service ids are ignored.
//  In-service masks a source (level or edge) until completed; new edges are still latched into pending.
//  Reset mid-claim: all state cleared at once, including in_service; no partial handshake survives.
// CONFIGURATION
//  INTC_SYNC_EN defined: two extra synchroniser flops ahead of sampled_r for asynchronous sources;
//    every input-to-pending latency grows by 2 cycles (level: k+2, edge: k+3).
//  Undefined: single sampling flop as above; interrupt_i must already be synchronous to clk_i.
// STRUCTURE
//  common package: intc_port_t enum (PENDING..RAW = 4'h0..4'h5), INTC_MAX_SOURCES = 32.
//  Sub-module intc_find_first: combinational lowest-set-bit encoder, 32-bit vector ->
//    {valid, 5-bit index}. Instantiated once for CLAIM.
//  Everything else lives in this module.
// TESTING
//  1 Reset: deassert reset_ni; write ENABLED=1, raise interrupt_i[0] (level)
//    -> interrupt_o=1 one edge later; PENDING read = 0x1.
//  2 Edge latch: MODE=0x4, ENABLED=0x4, pulse interrupt_i[2] for 1 cycle
//    -> PENDING=0x4 persists after the pulse; W1C 0x4 -> PENDING=0, interrupt_o=0.
//  3 Priority: enable 0x28, sources 3 and 5 active -> CLAIM reads 4.
//    Next CLAIM reads 6. Third CLAIM reads 0. ACTIVE=0.
//  4 Complete: after test 3, write CLAIM=4 with level source 3 still high
//    -> ACTIVE=0x8, interrupt_o=1. Write CLAIM=0 and CLAIM=40 -> no state change.
//  5 Simultaneous: edge source 1 rising in the same cycle as W1C of bit 1 -> PENDING bit 1 remains 1.
//  6 NUM_SOURCES=8: write ENABLED=0xFFFFFFFF -> reads 0xFF; interrupt_i[20] high -> RAW=0, interrupt_o=0.
//    With INTC_SYNC_EN: test-1 latency measures 3 edges.

Source files
------------

// File: rtl/priority_interrupt_controller_pkg.sv
// priority_interrupt_controller_pkg: register map and shared sizes for the interrupt controller
package priority_interrupt_controller_pkg;
  localparam int INTC_MAX_SOURCES = 32;
  typedef enum logic [3:0] {
    PENDING = 4'h0,
    ENABLED = 4'h1,
    ACTIVE  = 4'h2,
    MODE    = 4'h3,
    CLAIM   = 4'h4,
    RAW     = 4'h5
  } intc_port_t;
endpackage

// File: rtl/priority_interrupt_controller_if.sv
// priority_interrupt_controller_if: peripheral bus port of the interrupt controller
interface priority_interrupt_controller_if;
  logic        chip_select_i;
  logic [3:0]  addr_i;
  logic        read_enable_i;
  logic [31:0] read_data_o;
  logic [31:0] write_data_i;
  logic [3:0]  write_mask_i;
  modport master (output chip_select_i, addr_i, read_enable_i, write_data_i, write_mask_i, input read_data_o);
  modport slave (input chip_select_i, addr_i, read_enable_i, write_data_i, write_mask_i, output read_data_o);
endinterface

// File: rtl/intc_find_first.sv
// intc_find_first: lowest-set-bit encoder returning {valid, index}
module intc_find_first
  import priority_interrupt_controller_pkg::*;
(
  input  logic [INTC_MAX_SOURCES-1:0] vec_i,
  output logic                        valid_o,
  output logic [4:0]                  idx_o
);
  assign valid_o = |vec_i;
  always_comb begin
    idx_o = '0;
    for (int i = INTC_MAX_SOURCES - 1; i >= 0; i--) if (vec_i[i]) idx_o = 5'(i);
  end
endmodule

// File: rtl/priority_interrupt_controller.sv
// priority_interrupt_controller: level/edge interrupt sources with W1C pending and claim/complete.
// Defining INTC_SYNC_EN inserts a two-flop synchroniser ahead of the sampling flop.
module priority_interrupt_controller
  import priority_interrupt_controller_pkg::*;
#(
  parameter int NUM_SOURCES = 32
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] interrupt_i,
  output logic        interrupt_o,
  priority_interrupt_controller_if.slave bus
);
  localparam logic [31:0] SRC_MASK = 32'((64'd1 << NUM_SOURCES) - 64'd1);
  localparam logic [7:0]  NUM_ID   = 8'(NUM_SOURCES);
  logic [31:0] sampled_q, prev_q, pend_q, pend_d, en_q, en_d, mode_q, mode_d, insvc_q, insvc_d;
  logic [31:0] rdata_q, rdv, byte_m, pending, active, edge_set, claim_clr, cmp_clr, w1c, sync_in;
  logic        rd, wr, ff_valid, claim;
  logic [4:0]  ff_idx;
  logic [7:0]  cmp_id;
`ifdef INTC_SYNC_EN
  logic [31:0] sync1_q, sync2_q;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= interrupt_i & SRC_MASK;
      sync2_q <= sync1_q;
    end
  assign sync_in = sync2_q;
`else
  assign sync_in = interrupt_i & SRC_MASK;
`endif
  assign byte_m = {{8{bus.write_mask_i[3]}}, {8{bus.write_mask_i[2]}},
                   {8{bus.write_mask_i[1]}}, {8{bus.write_mask_i[0]}}};
  assign rd = bus.chip_select_i & bus.read_enable_i;
  assign wr = bus.chip_select_i & (|bus.write_mask_i);
  assign pending = (mode_q & pend_q) | (~mode_q & sampled_q);
  assign active = pending & en_q & ~insvc_q;
  assign interrupt_o = |active;
  intc_find_first u_find_first (.vec_i(active), .valid_o(ff_valid), .idx_o(ff_idx));
  assign claim = rd && bus.addr_i == CLAIM && ff_valid;
  assign cmp_id = bus.write_data_i[7:0];
  always_comb begin
    w1c = (wr && bus.addr_i == PENDING) ? bus.write_data_i & byte_m & mode_q : '0;
    en_d = (wr && bus.addr_i == ENABLED) ? ((en_q & ~byte_m) | (bus.write_data_i & byte_m)) & SRC_MASK : en_q;
    mode_d = (wr && bus.addr_i == MODE) ? ((mode_q & ~byte_m) | (bus.write_data_i & byte_m)) & SRC_MASK : mode_q;
    edge_set = sampled_q & ~prev_q & mode_q;
    claim_clr = claim ? 32'd1 << ff_idx : '0;
    cmp_clr = (wr && bus.addr_i == CLAIM && bus.write_mask_i[0] && cmp_id != 8'd0 && cmp_id <= NUM_ID)
              ? 32'd1 << (cmp_id - 8'd1) : '0;
    // a new edge beats any clear, but switching a bit's mode drops its latched state
    pend_d = ((pend_q & ~w1c & ~claim_clr) | edge_set) & ~(mode_q ^ mode_d);
    insvc_d = (insvc_q & ~cmp_clr) | claim_clr;
  end
  always_comb begin
    rdv = '0;
    case (intc_port_t'(bus.addr_i))
      PENDING: rdv = pending;
      ENABLED: rdv = en_q;
      ACTIVE:  rdv = active;
      MODE:    rdv = mode_q;
      CLAIM:   rdv = ff_valid ? 32'(ff_idx) + 32'd1 : '0;
      RAW:     rdv = sampled_q;
      default: rdv = '0;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      sampled_q <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      insvc_q   <= '0;
      rdata_q   <= '0;
    end else begin
      sampled_q <= sync_in;
      prev_q    <= sampled_q;
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      insvc_q   <= insvc_d;
      rdata_q   <= rd ? rdv : rdata_q;
    end
  assign bus.read_data_o = rdata_q;
endmodule

// File: tb/tb_priority_interrupt_controller.sv
// tb_priority_interrupt_controller: directed vectors for a 32-source and an 8-source controller
module tb_priority_interrupt_controller;
  import priority_interrupt_controller_pkg::*;
  localparam logic [1:0] OP_IDLE = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2;
`ifdef INTC_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif
  typedef struct {
    logic [1:0]  op;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] irq;
    logic [31:0] exp_rd;
    logic        exp_int;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n;
  logic [31:0] irq32, irq8, last32, last8;
  logic int32, int8;
  int n_cmp = 0, n_bad = 0;
  vec_t tv32[$], tv8[$];
  priority_interrupt_controller_if bus32();
  priority_interrupt_controller_if bus8();
  priority_interrupt_controller #(.NUM_SOURCES(32)) dut32 (
    .clk_i(clk), .reset_ni(reset_n), .interrupt_i(irq32), .interrupt_o(int32), .bus(bus32.slave));
  priority_interrupt_controller #(.NUM_SOURCES(8)) dut8 (
    .clk_i(clk), .reset_ni(reset_n), .interrupt_i(irq8), .interrupt_o(int8), .bus(bus8.slave));
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] op, logic [3:0] addr, logic [31:0] wd, logic [3:0] wm,
                              logic [31:0] irq, logic [31:0] exp_rd, logic exp_int);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.wm = wm; v.irq = irq; v.exp_rd = exp_rd; v.exp_int = exp_int;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit d8, input logic cs, input logic re, input logic [3:0] addr,
                       input logic [31:0] wd, input logic [3:0] wm, input logic [31:0] irq);
    if (d8) begin
      bus8.chip_select_i = cs; bus8.read_enable_i = re; bus8.addr_i = addr;
      bus8.write_data_i = wd; bus8.write_mask_i = wm; irq8 = irq; last8 = irq;
    end else begin
      bus32.chip_select_i = cs; bus32.read_enable_i = re; bus32.addr_i = addr;
      bus32.write_data_i = wd; bus32.write_mask_i = wm; irq32 = irq; last32 = irq;
    end
  endtask

  // With the synchroniser, a changed input is held for two idle cycles so each vector keeps its meaning
  task automatic run(input bit d8, input vec_t v, input string tag);
`ifdef INTC_SYNC_EN
    if (v.irq !== (d8 ? last8 : last32))
      repeat (2) begin
        @(negedge clk);
        drive(d8, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, v.irq);
      end
`endif
    @(negedge clk);
    drive(d8, v.op != OP_IDLE, v.op == OP_RD, v.addr, v.wd, v.op == OP_WR ? v.wm : 4'h0, v.irq);
    @(posedge clk);
    #1;
    if (v.op == OP_RD) chk({tag, " read_data"}, d8 ? bus8.read_data_o : bus32.read_data_o, v.exp_rd);
    chk({tag, " interrupt"}, 32'(d8 ? int8 : int32), 32'(v.exp_int));
    drive(d8, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, v.irq);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    last32 = 'x;
    last8 = 'x;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0);
    last32 = 'x;
    last8 = 'x;
    repeat (2) @(negedge clk);
    chk("reset read_data", bus32.read_data_o, 32'h0);
    chk("reset interrupt", 32'(int32), 32'h0);
    chk("reset8 interrupt", 32'(int8), 32'h0);
    reset_n = 1'b1;

    tv32.push_back(mk(OP_WR,   ENABLED, 32'h1,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h1,  32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h1,  32'h1, 1'b1));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   MODE,    32'h4,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   ENABLED, 32'h4,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h4,  32'h0, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h0,  32'h0, 1'b1));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h0,  32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h0,  32'h4, 1'b1));
    tv32.push_back(mk(OP_WR,   PENDING, 32'h4,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   MODE,    32'h0,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   ENABLED, 32'h28, 4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h28, 32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   CLAIM,   32'h0,  4'h0, 32'h28, 32'h4, 1'b1));
    tv32.push_back(mk(OP_RD,   CLAIM,   32'h0,  4'h0, 32'h28, 32'h6, 1'b0));
    tv32.push_back(mk(OP_RD,   CLAIM,   32'h0,  4'h0, 32'h28, 32'h0, 1'b0));
    tv32.push_back(mk(OP_RD,   ACTIVE,  32'h0,  4'h0, 32'h28, 32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   CLAIM,   32'h4,  4'h1, 32'h28, 32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   ACTIVE,  32'h0,  4'h0, 32'h28, 32'h8, 1'b1));
    tv32.push_back(mk(OP_WR,   CLAIM,   32'h0,  4'h1, 32'h28, 32'h0, 1'b1));
    tv32.push_back(mk(OP_WR,   CLAIM,   32'h28, 4'h1, 32'h28, 32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   ACTIVE,  32'h0,  4'h0, 32'h28, 32'h8, 1'b1));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h28, 32'h28, 1'b1));
    tv32.push_back(mk(OP_WR,   ENABLED, 32'h0,  4'hF, 32'h28, 32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   MODE,    32'h2,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h2,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   PENDING, 32'h2,  4'hF, 32'h2,  32'h0, 1'b0));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h2,  32'h2, 1'b0));
    tv32.push_back(mk(OP_WR,   MODE,    32'h0,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   MODE,    32'h2,  4'hF, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h0,  32'h0, 1'b0));
    tv32.push_back(mk(OP_WR,   ENABLED, 32'hFFFF_FFFF, 4'h2, 32'h0, 32'h0, 1'b0));
    tv32.push_back(mk(OP_RD,   ENABLED, 32'h0,  4'h0, 32'h0,  32'h0000_FF00, 1'b0));
    tv32.push_back(mk(OP_IDLE, 4'h0,    32'h0,  4'h0, 32'h101, 32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   RAW,     32'h0,  4'h0, 32'h101, 32'h101, 1'b1));
    tv32.push_back(mk(OP_WR,   PENDING, 32'h100, 4'hF, 32'h101, 32'h0, 1'b1));
    tv32.push_back(mk(OP_RD,   PENDING, 32'h0,  4'h0, 32'h101, 32'h101, 1'b1));
    tv32.push_back(mk(OP_RD,   4'h9,    32'h0,  4'h0, 32'h101, 32'h0, 1'b1));
    foreach (tv32[i]) run(1'b0, tv32[i], $sformatf("v32_%0d", i));

    tv8.push_back(mk(OP_WR,   ENABLED, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 1'b0));
    tv8.push_back(mk(OP_RD,   ENABLED, 32'h0, 4'h0, 32'h0,       32'hFF, 1'b0));
    tv8.push_back(mk(OP_IDLE, 4'h0,    32'h0, 4'h0, 32'h10_0000, 32'h0, 1'b0));
    tv8.push_back(mk(OP_RD,   RAW,     32'h0, 4'h0, 32'h10_0000, 32'h0, 1'b0));
    tv8.push_back(mk(OP_RD,   PENDING, 32'h0, 4'h0, 32'h10_0000, 32'h0, 1'b0));
    tv8.push_back(mk(OP_IDLE, 4'h0,    32'h0, 4'h0, 32'h80, 32'h0, 1'b1));
    tv8.push_back(mk(OP_RD,   CLAIM,   32'h0, 4'h0, 32'h80, 32'h8, 1'b0));
    tv8.push_back(mk(OP_WR,   CLAIM,   32'h9, 4'h1, 32'h80, 32'h0, 1'b0));
    tv8.push_back(mk(OP_WR,   CLAIM,   32'h8, 4'h2, 32'h80, 32'h0, 1'b0));
    tv8.push_back(mk(OP_WR,   CLAIM,   32'h8, 4'h1, 32'h80, 32'h0, 1'b1));
    tv8.push_back(mk(OP_RD,   ACTIVE,  32'h0, 4'h0, 32'h80, 32'h80, 1'b1));
    foreach (tv8[i]) run(1'b1, tv8[i], $sformatf("v8_%0d", i));

    // source 5 is still in service here, so enabling it must not raise the line
    run(1'b0, mk(OP_WR, ENABLED, 32'h20, 4'hF, 32'h20, 32'h0, 1'b0), "insvc_mask");
    @(negedge clk);
    #2 reset_n = 1'b0;
    last32 = 'x;
    last8 = 'x;
    #1;
    chk("async reset interrupt", 32'(int32), 32'h0);
    chk("async reset read_data", bus32.read_data_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run(1'b0, mk(OP_WR, ENABLED, 32'h20, 4'hF, 32'h20, 32'h0, 1'b1), "post_reset_en");
    run(1'b0, mk(OP_RD, CLAIM, 32'h0, 4'h0, 32'h20, 32'h6, 1'b0), "post_reset_claim");

    do_reset();
    run(1'b0, mk(OP_WR, ENABLED, 32'h1, 4'hF, 32'h0, 32'h0, 1'b0), "lat_en");
    @(negedge clk);
    irq32 = 32'h1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (int32) break;
    end
    chk("level latency", 32'(lat), 32'(EXP_LAT));
    chk("latency pending", 32'(dut32.pending[0]), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
